// File: rtl/io_coordinator_param.sv
// Host-to-RAM transfer sequencer: unpacks host words into RAM bytes in load mode and fetches
// the classifier result byte in cnn mode, with a request timeout and dropped-word tracking.
module io_coordinator_param #(
  parameter int unsigned       DIN_W     = 16,
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       CLS_W     = 4,
  parameter logic [ADDR_W-1:0] IMG_BASE  = '0,
  parameter int unsigned       IMG_WORDS = 392,
  parameter logic [ADDR_W-1:0] RES_ADDR  = '1,
  parameter int unsigned       TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              interrupt,
  input  logic              load,
  input  logic              cnn,
  input  logic [DIN_W-1:0]  Din,
  output logic [CLS_W-1:0]  Dout,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [DATA_W-1:0] ramDataOut,
  input  logic [DATA_W-1:0] ramDataIn,
  output logic              writeSignal,
  output logic              readSignal,
  input  logic              ramDoneWrite,
  input  logic              ramDoneRead,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              dropped
);

  localparam int unsigned BPW   = DIN_W / DATA_W;
  localparam int unsigned IdxW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned WcntW = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);

  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(BPW - 1);
  localparam logic [WcntW-1:0] WcntLast = WcntW'(IMG_WORDS - 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitWord,
    StWrReq,
    StWrWait,
    StRdReq,
    StRdWait,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WcntW-1:0]  wcnt_q, wcnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DIN_W-1:0]  word_q, word_d;
  logic [TmoW-1:0]   wait_q, wait_d;
  logic [CLS_W-1:0]  dout_q, dout_d;
  logic              error_q, error_d;
  logic              dropped_q, dropped_d;

  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              write_q, read_q, ready_q, busy_q, done_q;

  logic [DATA_W-1:0] cur_byte;
  logic              timeout;

  assign cur_byte = word_q[idx_q*DATA_W +: DATA_W];
  assign timeout  = (wait_q == TmoLast);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wcnt_d      = wcnt_q;
    idx_d       = idx_q;
    word_d      = word_q;
    wait_d      = wait_q;
    dout_d      = dout_q;
    error_d     = error_q;
    dropped_d   = dropped_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (load) begin
          state_d   = StWaitWord;
          addr_d    = IMG_BASE;
          wcnt_d    = '0;
          dropped_d = 1'b0;
        end else if (cnn) begin
          state_d = StRdReq;
        end
      end
      StWaitWord: begin
        if (interrupt) begin
          word_d  = Din;
          idx_d   = '0;
          state_d = StWrReq;
        end
      end
      StWrReq: begin
        ram_addr_d  = addr_q;
        ram_wdata_d = cur_byte;
        wait_d      = '0;
        state_d     = StWrWait;
      end
      StWrWait: begin
        // A completion arriving in the timeout cycle still counts as success.
        if (ramDoneWrite) begin
          addr_d = addr_q + ADDR_W'(1);
          if (idx_q != IdxLast) begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StWrReq;
          end else if (wcnt_q == WcntLast) begin
            state_d = StDone;
          end else begin
            wcnt_d  = wcnt_q + WcntW'(1);
            state_d = StWaitWord;
          end
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = StDone;
        end else begin
          wait_d = wait_q + TmoW'(1);
        end
      end
      StRdReq: begin
        ram_addr_d = RES_ADDR;
        wait_d     = '0;
        state_d    = StRdWait;
      end
      StRdWait: begin
        if (ramDoneRead) begin
          dout_d  = ramDataIn[CLS_W-1:0];
          state_d = StDone;
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = StDone;
        end else begin
          wait_d = wait_q + TmoW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Host strobes while a byte is in flight are lost.
    if (interrupt && (state_q == StWrReq || state_q == StWrWait)) begin
      dropped_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wcnt_q      <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      wait_q      <= '0;
      dout_q      <= '0;
      error_q     <= 1'b0;
      dropped_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wcnt_q      <= wcnt_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      wait_q      <= wait_d;
      dout_q      <= dout_d;
      error_q     <= error_d;
      dropped_q   <= dropped_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      write_q     <= (state_d == StWrWait);
      read_q      <= (state_d == StRdWait);
      ready_q     <= (state_d == StWaitWord);
      busy_q      <= (state_d != StIdle);
      done_q      <= (state_d == StDone);
    end
  end

  assign Dout        = dout_q;
  assign ramAddress  = ram_addr_q;
  assign ramDataOut  = ram_wdata_q;
  assign writeSignal = write_q;
  assign readSignal  = read_q;
  assign ready       = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign dropped     = dropped_q;

  if (CLS_W < DATA_W) begin : g_rdata_upper
    logic unused_rdata_upper;
    assign unused_rdata_upper = ^ramDataIn[DATA_W-1:CLS_W];
  end

endmodule

// File: tb/tb_io_coordinator_param.sv
// Randomised scoreboard bench for io_coordinator_param: a RAM/monitor process answers requests
// and checks writes and session results against expectations queued by the stimulus.
module tb_io_coordinator_param;

  localparam int unsigned WORDS = 2;
  localparam int unsigned TMO   = 8;
  localparam logic [15:0] BASE  = 16'h0100;
  localparam logic [15:0] RES   = 16'h0FFF;

  typedef struct packed {
    logic [3:0] dout;
    logic       err;
    logic       drop;
    logic       chk_drop;
  } sess_t;

  logic        clk = 1'b0;
  logic        rst, interrupt, load, cnn;
  logic [15:0] din;
  logic [3:0]  dout;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        wr, rd, done_wr, done_rd;
  logic        ready, busy, done, error, dropped;

  // Second instance exercising address wrap with a one-word session.
  logic        w_interrupt, w_load, w_cnn;
  logic [15:0] w_din;
  logic [3:0]  w_dout;
  logic [15:0] w_addr;
  logic [7:0]  w_wdata, w_rdata;
  logic        w_wr, w_rd, w_done_wr, w_done_rd;
  logic        w_ready, w_busy, w_done, w_error, w_dropped;

  int checks = 0;
  int errors = 0;

  // Reference model state
  sess_t       exp_sess[$];
  logic [23:0] exp_wr[$];
  logic [23:0] w_got[$];
  logic [3:0]  dout_m;
  logic        err_m;

  // RAM behaviour controls set by stimulus
  int          wr_lat, rd_lat;
  bit          wr_ok, rd_ok;
  logic [7:0]  res_byte;

  // Monitor state
  int          wr_hi, rd_hi;
  bit          wr_ans, rd_ans, prev_done;

  always #5 clk = ~clk;

  io_coordinator_param #(
    .DIN_W(16), .DATA_W(8), .ADDR_W(16), .CLS_W(4), .IMG_BASE(BASE),
    .IMG_WORDS(WORDS), .RES_ADDR(RES), .TIMEOUT(TMO)
  ) u_dut (
    .clk(clk), .RST(rst), .interrupt(interrupt), .load(load), .cnn(cnn), .Din(din),
    .Dout(dout), .ramAddress(ram_addr), .ramDataOut(ram_wdata), .ramDataIn(ram_rdata),
    .writeSignal(wr), .readSignal(rd), .ramDoneWrite(done_wr), .ramDoneRead(done_rd),
    .ready(ready), .busy(busy), .done(done), .error(error), .dropped(dropped)
  );

  io_coordinator_param #(
    .DIN_W(16), .DATA_W(8), .ADDR_W(16), .CLS_W(4), .IMG_BASE(16'hFFFF),
    .IMG_WORDS(1), .RES_ADDR(RES), .TIMEOUT(TMO)
  ) u_wrap (
    .clk(clk), .RST(rst), .interrupt(w_interrupt), .load(w_load), .cnn(w_cnn), .Din(w_din),
    .Dout(w_dout), .ramAddress(w_addr), .ramDataOut(w_wdata), .ramDataIn(w_rdata),
    .writeSignal(w_wr), .readSignal(w_rd), .ramDoneWrite(w_done_wr), .ramDoneRead(w_done_rd),
    .ready(w_ready), .busy(w_busy), .done(w_done), .error(w_error), .dropped(w_dropped)
  );

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // RAM model + monitor: answers requests and compares everything the DUT presents.
  always @(negedge clk) begin
    if (rst) begin
      wr_hi = 0; rd_hi = 0; wr_ans = 0; rd_ans = 0; prev_done = 0;
      done_wr = 0; done_rd = 0; ram_rdata = '0;
    end else begin
      if (wr) begin
        wr_hi++;
        if (!wr_ans && wr_ok && wr_hi > wr_lat) begin
          done_wr = 1; wr_ans = 1;
          if (exp_wr.size() == 0) chk("wr_unexpected", {ram_addr, ram_wdata}, 24'h0);
          else chk("wr_addr_data", {ram_addr, ram_wdata}, exp_wr.pop_front());
        end else begin
          done_wr = 0;
        end
      end else begin
        done_wr = 0;
        if (wr_hi > 0) chk("wr_len", wr_hi, wr_ans ? wr_lat + 1 : TMO);
        wr_hi = 0; wr_ans = 0;
      end

      if (rd) begin
        rd_hi++;
        chk("rd_addr", ram_addr, RES);
        if (!rd_ans && rd_ok && rd_hi > rd_lat) begin
          done_rd = 1; rd_ans = 1; ram_rdata = res_byte;
        end else begin
          done_rd = 0; ram_rdata = 8'($urandom);
        end
      end else begin
        done_rd = 0; rd_hi = 0; rd_ans = 0; ram_rdata = 8'($urandom);
      end

      if (prev_done) begin
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
      end
      if (done) begin
        if (exp_sess.size() == 0) begin
          chk("done_unexpected", done, 0);
        end else begin
          sess_t s;
          s = exp_sess.pop_front();
          chk("sess_dout", dout, s.dout);
          chk("sess_error", error, s.err);
          if (s.chk_drop) begin
            chk("sess_dropped", dropped, s.drop);
            chk("wr_left", exp_wr.size(), 0);
          end
        end
      end
      prev_done = done;
    end
  end

  always @(negedge clk) begin
    w_done_wr = w_wr;
    if (w_wr && !rst) w_got.push_back({w_addr, w_wdata});
  end

  task automatic wait_ready();
    int g = 0;
    while (!ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk("ready_wait", ready, 1);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk("idle_wait", busy, 0);
  endtask

  task automatic load_session(input logic [15:0] w0, input logic [15:0] w1, input int lat,
                              input bit ok, input bit drop);
    logic [15:0] words[2];
    logic [15:0] a;
    bit          answered;
    sess_t       s;
    words[0] = w0; words[1] = w1;
    wr_lat   = lat; wr_ok = ok;
    answered = ok && (lat + 1 <= TMO);
    if (!answered) err_m = 1;
    s = '{dout: dout_m, err: err_m, drop: drop, chk_drop: 1'b1};
    exp_sess.push_back(s);
    a = BASE;
    @(posedge clk); #1 load = 1;
    @(posedge clk); #1 load = 0;
    for (int w = 0; w < (answered ? WORDS : 1); w++) begin
      wait_ready();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      din = words[w]; interrupt = 1;
      if (answered) begin
        for (int b = 0; b < 2; b++) begin
          exp_wr.push_back({a, 8'(words[w] >> (8 * b))});
          a = a + 16'd1;
        end
      end
      @(posedge clk); #1 interrupt = 0;
      if (drop && w == 0) begin
        @(posedge clk); #1 interrupt = 1; din = ~words[w];
        @(posedge clk); #1 interrupt = 0;
      end
    end
    wait_idle();
  endtask

  task automatic read_session(input logic [7:0] data, input int lat, input bit ok,
                              input bit chk_lat);
    sess_t s;
    int    cyc;
    res_byte = data; rd_lat = lat; rd_ok = ok;
    if (ok && lat + 1 <= TMO) dout_m = data[3:0];
    else err_m = 1;
    s = '{dout: dout_m, err: err_m, drop: 1'b0, chk_drop: 1'b0};
    exp_sess.push_back(s);
    @(posedge clk); #1 cnn = 1;
    @(posedge clk); #1 cnn = 0;
    cyc = 1;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (chk_lat) chk("rd_latency", cyc, 3);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1; interrupt = 0; load = 0; cnn = 0; din = '0;
    w_interrupt = 0; w_load = 0; w_cnn = 0; w_din = '0; w_rdata = '0; w_done_rd = 0;
    wr_lat = 0; rd_lat = 0; wr_ok = 1; rd_ok = 1; res_byte = '0;
    dout_m = '0; err_m = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_dout", dout, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_wr", wr, 0);
    chk("rst_rd", rd, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_dropped", dropped, 0);

    load_session(16'hBEEF, 16'h1234, 0, 1, 0);
    read_session(8'hA7, 0, 1, 1);
    load_session(16'($urandom), 16'($urandom), 1, 1, 1);
    // Completion arriving in the same cycle as the timeout must win.
    load_session(16'($urandom), 16'($urandom), TMO - 1, 1, 0);
    load_session(16'($urandom), 16'($urandom), 0, 0, 0);
    load_session(16'($urandom), 16'($urandom), 0, 1, 0);

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1)
        load_session(16'($urandom), 16'($urandom), $urandom_range(0, 3), 1,
                     $urandom_range(0, 1) == 1);
      else
        read_session(8'($urandom), $urandom_range(0, 3), $urandom_range(0, 5) != 0, 0);
    end
    read_session(8'h5C, 1, 1, 0);

    // Reset in the middle of a write handshake.
    wr_ok = 0;
    @(posedge clk); #1 load = 1;
    @(posedge clk); #1 load = 0; din = 16'h5555; interrupt = 1;
    @(posedge clk); #1 interrupt = 0;
    @(posedge clk); #1;
    chk("wr_before_rst", wr, 1);
    rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_wr", wr, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_dout", dout, 0);
    chk("rst_mid_error", error, 0);
    rst = 0; err_m = 0; dout_m = '0;
    exp_wr.delete(); exp_sess.delete(); w_got.delete();
    load_session(16'($urandom), 16'($urandom), 2, 1, 0);

    // Address wrap on the second instance.
    @(posedge clk); #1 w_load = 1;
    @(posedge clk); #1 w_load = 0;
    chk("wrap_ready", w_ready, 1);
    w_din = 16'hCAFE; w_interrupt = 1;
    @(posedge clk); #1 w_interrupt = 0;
    begin
      int g = 0;
      while (w_busy && g < 100) begin
        @(posedge clk); #1;
        g++;
      end
    end
    chk("wrap_idle", w_busy, 0);
    chk("wrap_count", w_got.size(), 2);
    if (w_got.size() == 2) begin
      chk("wrap_byte0", w_got[0], 24'hFFFFFE);
      chk("wrap_byte1", w_got[1], 24'h0000CA);
    end
    chk("wrap_error", w_error, 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
